// File: rtl/event_log_pkg.sv
// event_log_pkg: severity encodings and saturating-increment helper for event_log
package event_log_pkg;
  localparam logic [1:0] SEV_INFO    = 2'd0;
  localparam logic [1:0] SEV_WARNING = 2'd1;
  localparam logic [1:0] SEV_ERROR   = 2'd2;
  localparam logic [1:0] SEV_FATAL   = 2'd3;
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    return ((v & mask) == mask) ? v : v + 64'd1;
  endfunction
endpackage

// File: rtl/event_log_fifo.sv
// event_log_fifo: synchronous first-word-fall-through FIFO with valid/ready read side
module event_log_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic             rvalid,
  input  logic             rready,
  output logic [WIDTH-1:0] rdata
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic pop, wr;
  assign empty  = count == '0;
  assign full   = count == (AW+1)'(DEPTH);
  assign rvalid = !empty;
  assign pop    = rvalid & rready;
  // a full FIFO still takes a write when the head leaves in the same cycle
  assign wr     = push & (!full | pop);
  assign rdata  = rvalid ? mem[rd_ptr] : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count  <= count + (AW+1)'(wr) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (wr && !clear) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/event_log.sv
// event_log: timestamps severity-tagged events, counts them per severity and
// buffers them in a FIFO drained over valid/ready; a fatal event freezes intake.
module event_log
  import event_log_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int CODE_WIDTH = 8,
  parameter int TS_WIDTH   = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  in_valid,
  input  logic [1:0]            in_severity,
  input  logic [CODE_WIDTH-1:0] in_code,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:0]            out_severity,
  output logic [CODE_WIDTH-1:0] out_code,
  output logic [TS_WIDTH-1:0]   out_timestamp,
  output logic [CNT_WIDTH-1:0]  nb_info,
  output logic [CNT_WIDTH-1:0]  nb_warning,
  output logic [CNT_WIDTH-1:0]  nb_error,
  output logic [CNT_WIDTH-1:0]  dropped,
  output logic                  fatal
);
  localparam int EW = 2 + CODE_WIDTH + TS_WIDTH;
  logic [TS_WIDTH-1:0] ts;
  logic [EW-1:0] rdata;
  logic accept, pop, full, empty, drop;
  assign accept = in_valid & !fatal & !clear;
  assign pop    = out_valid & out_ready;
  assign drop   = accept & full & !pop;
  assign {out_severity, out_code, out_timestamp} = rdata;
  event_log_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .push   (accept),
    .wdata  ({in_severity, in_code, ts}),
    .full   (full),
    .empty  (empty),
    .rvalid (out_valid),
    .rready (out_ready),
    .rdata  (rdata)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) ts <= '0;
    else ts <= ts + 1'b1;
  // severity counters count accepted events even when the entry is dropped
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      nb_info    <= '0;
      nb_warning <= '0;
      nb_error   <= '0;
      dropped    <= '0;
      fatal      <= 1'b0;
    end else if (clear) begin
      nb_info    <= '0;
      nb_warning <= '0;
      nb_error   <= '0;
      dropped    <= '0;
      fatal      <= 1'b0;
    end else begin
      nb_info    <= (accept && in_severity == SEV_INFO) ? CNT_WIDTH'(sat_inc(64'(nb_info), CNT_WIDTH)) : nb_info;
      nb_warning <= (accept && in_severity == SEV_WARNING) ? CNT_WIDTH'(sat_inc(64'(nb_warning), CNT_WIDTH)) : nb_warning;
      nb_error   <= (accept && in_severity == SEV_ERROR) ? CNT_WIDTH'(sat_inc(64'(nb_error), CNT_WIDTH)) : nb_error;
      dropped    <= drop ? CNT_WIDTH'(sat_inc(64'(dropped), CNT_WIDTH)) : dropped;
      fatal      <= fatal | (accept && in_severity == SEV_FATAL);
    end
endmodule

// File: tb/tb_event_log.sv
// tb_event_log: directed vectors for event_log, including a narrow-counter instance for saturation.
module tb_event_log;
  logic clk = 1'b0, rst = 1'b1, clear = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic [1:0] in_severity = 2'd0;
  logic [7:0] in_code = 8'd0;
  logic out_valid, fatal;
  logic [1:0] out_severity;
  logic [7:0] out_code;
  logic [31:0] out_timestamp;
  logic [15:0] nb_info, nb_warning, nb_error, dropped;
  logic s_valid = 1'b0;
  logic s_out_valid, s_fatal;
  logic [1:0] s_out_severity;
  logic [7:0] s_out_code;
  logic [31:0] s_out_timestamp;
  logic [3:0] s_nb_info, s_nb_warning, s_nb_error, s_dropped;
  int vectors = 0, miscompares = 0;
  logic [31:0] tb_ts;
  logic [31:0] ts_log [19];
  logic [31:0] ts40;

  always #5 clk = ~clk;
  always @(posedge clk or posedge rst)
    if (rst) tb_ts <= 0;
    else tb_ts <= tb_ts + 1;

  event_log dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_severity(in_severity),
    .in_code(in_code), .out_valid(out_valid), .out_ready(out_ready), .out_severity(out_severity),
    .out_code(out_code), .out_timestamp(out_timestamp), .nb_info(nb_info), .nb_warning(nb_warning),
    .nb_error(nb_error), .dropped(dropped), .fatal(fatal)
  );

  event_log #(.DEPTH(4), .CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst(rst), .clear(1'b0), .in_valid(s_valid), .in_severity(2'd0),
    .in_code(8'h5A), .out_valid(s_out_valid), .out_ready(1'b1), .out_severity(s_out_severity),
    .out_code(s_out_code), .out_timestamp(s_out_timestamp), .nb_info(s_nb_info),
    .nb_warning(s_nb_warning), .nb_error(s_nb_error), .dropped(s_dropped), .fatal(s_fatal)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    repeat (2) tick();
    check("rst_valid", out_valid, 0);
    check("rst_code", out_code, 0);
    check("rst_ts", out_timestamp, 0);
    check("rst_fatal", fatal, 0);
    check("rst_info", nb_info, 0);
    rst = 1'b0;
    // info event at timestamp 5
    repeat (5) tick();
    in_valid = 1'b1; in_severity = 2'd0; in_code = 8'h11; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("ev1_valid", out_valid, 1);
    check("ev1_entry", {out_severity, out_code, out_timestamp}, {2'd0, 8'h11, 32'd5});
    check("ev1_info", nb_info, 1);
    tick();
    check("ev1_popped", out_valid, 0);
    // overflow: 19 error events with the consumer stalled
    out_ready = 1'b0;
    for (int i = 0; i < 19; i++) begin
      in_valid = 1'b1; in_severity = 2'd2; in_code = 8'h20 + 8'(i); ts_log[i] = tb_ts;
      tick();
    end
    in_valid = 1'b0;
    check("ovf_error", nb_error, 19);
    check("ovf_dropped", dropped, 3);
    check("ovf_head_code", out_code, 8'h20);
    check("ovf_head_ts", out_timestamp, ts_log[0]);
    // push and pop together on a full FIFO
    in_valid = 1'b1; in_code = 8'h40; out_ready = 1'b1; ts40 = tb_ts;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    check("pp_head", out_code, 8'h21);
    check("pp_dropped", dropped, 3);
    check("pp_error", nb_error, 20);
    in_valid = 1'b1; in_code = 8'h41;
    tick();
    in_valid = 1'b0;
    check("pp_still_full", dropped, 4);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("drain_valid", out_valid, 1);
      check("drain_code", out_code, (i < 15) ? 8'h21 + 8'(i) : 8'h40);
      check("drain_ts", out_timestamp, (i < 15) ? ts_log[i+1] : ts40);
      tick();
    end
    out_ready = 1'b0;
    check("drain_empty", out_valid, 0);
    // fatal freeze
    in_valid = 1'b1; in_severity = 2'd3; in_code = 8'hFF;
    tick();
    check("fatal_set", fatal, 1);
    in_severity = 2'd1; in_code = 8'h33;
    repeat (4) tick();
    in_valid = 1'b0;
    check("fatal_warn", nb_warning, 0);
    check("fatal_dropped", dropped, 4);
    check("fatal_entry", {out_valid, out_severity, out_code}, {1'b1, 2'd3, 8'hFF});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("fatal_only", out_valid, 0);
    // clear with a concurrent event
    in_valid = 1'b1; in_severity = 2'd3; in_code = 8'h55;
    tick();
    clear = 1'b1; in_severity = 2'd0;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    check("clr_fatal", fatal, 0);
    check("clr_info", nb_info, 0);
    check("clr_error", nb_error, 0);
    check("clr_dropped", dropped, 0);
    check("clr_out", {out_valid, out_severity, out_code, out_timestamp}, 0);
    // async reset mid-drain
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_severity = 2'd0; in_code = 8'h60 + 8'(i);
      tick();
    end
    in_valid = 1'b0;
    check("q_info", nb_info, 5);
    out_ready = 1'b1;
    repeat (2) tick();
    check("q_head", out_code, 8'h62);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_info", nb_info, 0);
    check("arst_out", {out_code, out_timestamp}, 0);
    tick();
    rst = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    in_valid = 1'b1; in_severity = 2'd1; in_code = 8'h77;
    tick();
    in_valid = 1'b0;
    check("arst_ts", {out_valid, out_code, out_timestamp}, {1'b1, 8'h77, 32'd3});
    check("arst_warn", nb_warning, 1);
    // 4-bit counter saturation
    s_valid = 1'b1;
    repeat (14) tick();
    check("sat_14", s_nb_info, 14);
    tick();
    check("sat_15", s_nb_info, 15);
    repeat (5) tick();
    s_valid = 1'b0;
    check("sat_hold", s_nb_info, 15);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/event_log.md
# event_log

Synthesizable event logger and read-out side of the simulation report flow. Hardware blocks post severity-tagged event codes (info, warning, error, fatal). The block timestamps each event, keeps saturating per-severity counters and buffers entries in a FIFO. A host or debug bridge drains the FIFO through a valid/ready stream. A sticky fatal flag freezes logging until cleared.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, at least 2.
- `CODE_WIDTH`, 8: event code width.
- `TS_WIDTH`, 32: timestamp width.
- `CNT_WIDTH`, 16: per-severity counter width.
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `clear`  in  1  synchronous clear of counters, `dropped`, `fatal` and FIFO contents; the timestamp is not cleared.
- `in_valid`  in  1  event strobe, one event per cycle.
- `in_severity`  in  2  0=info, 1=warning, 2=error, 3=fatal.
- `in_code`  in  CODE_WIDTH  event identifier.
- `out_valid`  out  1  head entry available.
- `out_ready`  in  1  consumer accepts the head entry.
- `out_severity`  out  2  head entry severity.
- `out_code`  out  CODE_WIDTH  head entry code.
- `out_timestamp`  out  TS_WIDTH  cycle count at event capture.
- `nb_info`, `nb_warning`, `nb_error`  out  CNT_WIDTH each  saturating counts of events accepted at that severity.
- `dropped`  out  CNT_WIDTH  saturating count of events lost because the FIFO was full.
- `fatal`  out  1  sticky; set when a fatal event is accepted.

## Operation
- Timestamp is a free-running counter.
  - 0 on reset, +1 every cycle, wraps modulo 2^TS_WIDTH.
  - An event captured in cycle N carries the counter value of cycle N.
- Event acceptance (`in_valid`=1, `fatal`=0, `clear`=0):
  - The matching counter increments, saturating at all-ones.
  - A fatal event increments no counter.
  - The entry is pushed if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise the entry is discarded and `dropped` increments (saturating).
  - Severity counters increment even when the entry is dropped.
- Fatal handling:
  - Accepting a fatal event pushes it (same full rules) and sets `fatal` on the next edge.
  - While `fatal`=1, `in_valid` is ignored: no push, no count, no drop count.
  - The output stream keeps draining normally.
- `clear`:
  - Empties the FIFO and zeroes counters, `dropped` and `fatal` on the next edge.
  - An event presented in the same cycle is ignored.
  - `clear` has priority over push and pop.
- Output handshake: standard valid/ready.
  - A pop happens when `out_valid` and `out_ready` are both 1.
  - `out_*` data is stable while `out_valid`=1 and `out_ready`=0.
- Simultaneous push and pop on a full FIFO: both occur and the occupancy stays at DEPTH.
- Push into an empty FIFO with a pop the same cycle is impossible, because `out_valid` is 0 in that cycle.

## Timing
- Reset values of all outputs:
  - `out_valid`=0, `out_severity`=0, `out_code`=0, `out_timestamp`=0.
  - All counters and `dropped` = 0; `fatal`=0.
- Event to counter update: 1 cycle (registered).
- Event to `out_valid` on an empty FIFO: 1 cycle. The FIFO is first-word-fall-through with registered outputs.
- Back-to-back events: 1 per cycle sustained while the consumer pops 1 per cycle.
- Asserting `rst` mid-stream:
  - Immediately discards all entries and forces every output to its reset value.
  - The timestamp restarts at 0 after release.
- Occupancy counter is log2(DEPTH)+1 bits. Read and write pointers are log2(DEPTH) bits and wrap naturally.

## Structure
- Package `event_log_pkg`:
  - Severity constants `SEV_INFO`=0, `SEV_WARNING`=1, `SEV_ERROR`=2, `SEV_FATAL`=3.
  - A saturating-increment function.
- Sub-module `event_log_fifo`:
  - Generic synchronous FWFT FIFO with WIDTH and DEPTH parameters.
  - Entry word is {severity, code, timestamp}, 2+CODE_WIDTH+TS_WIDTH bits.
  - Exposes `full`, `empty` and valid/ready on the read side.
- Top level holds the timestamp counter, severity counters, drop counter, fatal latch and the acceptance/clear control.

## Test plan
- Reset, then an info event code 0x11 at timestamp 5 with `out_ready`=1 → `out_valid` at cycle 6 with {0, 0x11, 5}; `nb_info`=1 at cycle 6.
- `out_ready`=0, DEPTH+3 consecutive error events → FIFO holds the first DEPTH events in order; `dropped`=3; `nb_error`=DEPTH+3.
- Full FIFO with push and pop in the same cycle → occupancy stays DEPTH, `dropped` unchanged, and the popped entry is the oldest.
- Fatal event code 0xFF, then 4 warning events → `fatal`=1 one cycle later; `nb_warning`=0; the FIFO contains the fatal entry only; `clear` returns all outputs to 0.
- Force `nb_info` to all-ones via 2^CNT_WIDTH info events (or CNT_WIDTH=4 with 20 events) → the counter holds at 15 and does not wrap.
- Assert `rst` asynchronously mid-drain with 5 entries queued → `out_valid` drops immediately, all counters read 0, and the timestamp restarts at 0 after release.
